// File: rtl/adder_arbiter.sv
// Round-robin arbiter time-sharing one WIDTH-bit adder among NUM_REQ requesters.
// The sum is registered with carry/overflow flags and returned to its owner via valid/ready.
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPCNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data1_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data2_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic [WIDTH-1:0]         resp_data_o,
  output logic                     resp_carry_o,
  output logic                     resp_ovf_o,
  output logic [OPCNT_W-1:0]       op_cnt_o
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PtrW-1:0] idx_t;

  logic               full_q, full_d;
  idx_t               owner_q, owner_d;
  idx_t               ptr_q, ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [OPCNT_W-1:0] cnt_q, cnt_d;

  logic             drain, can_issue, accept, grant_found;
  idx_t             grant_idx, cand;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum;

  assign drain     = full_q & resp_ready_i[owner_q];
  assign can_issue = ~full_q | drain;
  assign accept    = grant_found & can_issue;

  // First valid requester at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = idx_t'((32'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == idx_t'(k)) begin
        op_a = req_data1_i[k*WIDTH +: WIDTH];
        op_b = req_data2_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (drain) begin
      full_d = 1'b0;
      cnt_d  = cnt_q + OPCNT_W'(1);
    end
    // An accept during a drain reloads the register on the same edge.
    if (accept) begin
      full_d  = 1'b1;
      owner_d = grant_idx;
      ptr_d   = idx_t'((32'(grant_idx) + 1) % NUM_REQ);
      data_d  = sum[WIDTH-1:0];
      carry_d = sum[WIDTH];
      ovf_d   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o  = (rst_i && accept) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign resp_valid_o = full_q ? (NUM_REQ'(1) << owner_q) : '0;
  assign resp_data_o  = data_q;
  assign resp_carry_o = carry_q;
  assign resp_ovf_o   = ovf_q;
  assign op_cnt_o     = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: per-requester expected-result queues filled at issue,
// and a negedge monitor that checks grants, responses and the op counter against a model.
module tb_adder_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned OPCNT_W = 4;
  localparam int unsigned QD      = 64;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic [NUM_REQ-1:0]       req_valid_i = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data1_i = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data2_i = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [NUM_REQ-1:0]       resp_ready_i = '0;
  logic [WIDTH-1:0]         resp_data_o;
  logic                     resp_carry_o;
  logic                     resp_ovf_o;
  logic [OPCNT_W-1:0]       op_cnt_o;

  adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .OPCNT_W(OPCNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data1_i (req_data1_i),
    .req_data2_i (req_data2_i),
    .req_ready_o (req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o (resp_data_o),
    .resp_carry_o(resp_carry_o),
    .resp_ovf_o  (resp_ovf_o),
    .op_cnt_o    (op_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {ovf, carry, data} per requester, written at issue, consumed at drain
  logic [WIDTH+1:0]   exp_mem [NUM_REQ][QD];
  int unsigned        wr_ix [NUM_REQ];
  int unsigned        rd_ix [NUM_REQ];
  int                 n_vec = 0;
  int                 n_err = 0;
  logic [NUM_REQ-1:0] hs = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // True-arithmetic reference: overflow is when the wrapped signed result differs from the
  // mathematically exact signed sum.
  task automatic issue(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] u;
    longint      s;
    logic        ovf;
    u   = {32'b0, a} + {32'b0, b};
    s   = longint'($signed(a)) + longint'($signed(b));
    ovf = (s != longint'($signed(u[31:0])));
    exp_mem[k][wr_ix[k] % QD] = {ovf, u[32], u[31:0]};
    wr_ix[k]++;
    req_data1_i[k*WIDTH +: WIDTH] = a;
    req_data2_i[k*WIDTH +: WIDTH] = b;
    req_valid_i[k] = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7fff_ffff;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic sample();
    @(negedge clk_i);
    hs = req_valid_i & req_ready_o;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NUM_REQ; k++) if (hs[k]) req_valid_i[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #3;
    rst_i        = 1'b0;
    req_valid_i  = '0;
    resp_ready_i = '0;
    hs           = '0;
    #1;
    check("rst_req_ready", 64'(req_ready_o), 64'(0));
    check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("rst_data", 64'(resp_data_o), 64'(0));
    check("rst_carry", 64'(resp_carry_o), 64'(0));
    check("rst_ovf", 64'(resp_ovf_o), 64'(0));
    check("rst_op_cnt", 64'(op_cnt_o), 64'(0));
    req_valid_i = '1;  // grants must stay low while reset is held
    @(negedge clk_i);
    @(posedge clk_i);
    #3;
    req_valid_i = '0;
    rst_i       = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: reference model of pointer, held result and counter, derived from the rules.
  initial begin : monitor
    int               m_ptr, m_owner, m_cnt, g, c;
    bit               m_full, can;
    logic [NUM_REQ-1:0] eg;
    logic [WIDTH+1:0] e, m_last;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_full = 0; m_last = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        check("mon_rst_req_ready", 64'(req_ready_o), 64'(0));
        check("mon_rst_resp_valid", 64'(resp_valid_o), 64'(0));
        check("mon_rst_op_cnt", 64'(op_cnt_o), 64'(0));
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_full = 0; m_last = '0;
        for (int k = 0; k < NUM_REQ; k++) rd_ix[k] = wr_ix[k];
      end else begin
        eg  = '0;
        g   = -1;
        can = !m_full || resp_ready_i[m_owner];
        if (can) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            c = (m_ptr + i) % NUM_REQ;
            if (g < 0 && req_valid_i[c]) g = c;
          end
        end
        if (g >= 0) eg[g] = 1'b1;
        check("grant", 64'(req_ready_o), 64'(eg));
        if (m_full) begin
          e = exp_mem[m_owner][rd_ix[m_owner] % QD];
          check("resp_valid", 64'(resp_valid_o), 64'(NUM_REQ'(1) << m_owner));
        end else begin
          e = m_last;
          check("resp_valid_idle", 64'(resp_valid_o), 64'(0));
        end
        check("resp_data", 64'(resp_data_o), 64'(e[WIDTH-1:0]));
        check("resp_carry", 64'(resp_carry_o), 64'(e[WIDTH]));
        check("resp_ovf", 64'(resp_ovf_o), 64'(e[WIDTH+1]));
        check("op_cnt", 64'(op_cnt_o), 64'(m_cnt));
        if (m_full && resp_ready_i[m_owner]) begin
          rd_ix[m_owner]++;
          m_cnt  = (m_cnt + 1) % (1 << OPCNT_W);
          m_full = 0;
        end
        if (g >= 0) begin
          m_full  = 1;
          m_owner = g;
          m_ptr   = (g + 1) % NUM_REQ;
          m_last  = exp_mem[g][rd_ix[g] % QD];
        end
      end
    end
  end

  initial begin : stimulus
    int               rr_order [5];
    logic [WIDTH-1:0] fa [3];
    logic [WIDTH-1:0] fb [3];
    logic [WIDTH-1:0] fs [3];
    logic             fc [3];
    logic             fo [3];
    for (int k = 0; k < NUM_REQ; k++) begin
      wr_ix[k] = 0;
      rd_ix[k] = 0;
    end
    do_reset();

    // Single request from requester 2
    issue(2, 32'h5, 32'h7);
    sample();
    check("single_grant", 64'(req_ready_o), 64'(4'b0100));
    advance();
    resp_ready_i = 4'b0100;
    sample();
    check("single_valid", 64'(resp_valid_o), 64'(4'b0100));
    check("single_data", 64'(resp_data_o), 64'(32'hC));
    check("single_carry", 64'(resp_carry_o), 64'(0));
    check("single_ovf", 64'(resp_ovf_o), 64'(0));
    advance();
    sample();
    check("single_cnt", 64'(op_cnt_o), 64'(1));
    check("single_idle", 64'(resp_valid_o), 64'(0));
    advance();

    // Flag corners
    fa[0] = 32'h7fff_ffff; fb[0] = 32'h1;          fs[0] = 32'h8000_0000; fc[0] = 0; fo[0] = 1;
    fa[1] = 32'hffff_ffff; fb[1] = 32'h1;          fs[1] = 32'h0;         fc[1] = 1; fo[1] = 0;
    fa[2] = 32'h8000_0000; fb[2] = 32'h8000_0000;  fs[2] = 32'h0;         fc[2] = 1; fo[2] = 1;
    resp_ready_i = '1;
    for (int v = 0; v < 3; v++) begin
      issue(0, fa[v], fb[v]);
      sample();
      advance();
      sample();
      check("flag_data", 64'(resp_data_o), 64'(fs[v]));
      check("flag_carry", 64'(resp_carry_o), 64'(fc[v]));
      check("flag_ovf", 64'(resp_ovf_o), 64'(fo[v]));
      advance();
    end

    // Round-robin from reset with all four requesters continuously valid
    do_reset();
    rr_order = '{0, 1, 2, 3, 0};
    resp_ready_i = '1;
    for (int k = 0; k < NUM_REQ; k++) issue(k, $urandom, $urandom);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("rr_order", 64'(hs), 64'(NUM_REQ'(1) << rr_order[i]));
      if (i > 0) check("rr_no_bubble", 64'(resp_valid_o), 64'(NUM_REQ'(1) << rr_order[i-1]));
      advance();
      issue(rr_order[i], $urandom, $urandom);
    end

    // Backpressure: owner 1 stalls for 5 cycles while requester 3 waits
    do_reset();
    resp_ready_i = '0;
    issue(1, 32'h1111_1111, 32'h2222_2222);
    sample();
    advance();
    issue(3, 32'h1, 32'h2);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_no_grant", 64'(req_ready_o), 64'(0));
      check("bp_held_valid", 64'(resp_valid_o), 64'(4'b0010));
      check("bp_held_data", 64'(resp_data_o), 64'(32'h3333_3333));
      advance();
    end
    resp_ready_i = 4'b0010;
    sample();
    check("bp_release_grant", 64'(req_ready_o), 64'(4'b1000));
    advance();
    sample();
    check("bp_next_valid", 64'(resp_valid_o), 64'(4'b1000));
    check("bp_next_data", 64'(resp_data_o), 64'(32'h3));
    advance();
    resp_ready_i = 4'b1000;
    sample();
    advance();

    // Counter wrap: 17 completions with a 4-bit counter
    do_reset();
    resp_ready_i = '1;
    for (int i = 0; i < 17; i++) begin
      issue(0, $urandom, $urandom);
      sample();
      advance();
    end
    sample();
    advance();
    sample();
    check("cnt_wrap", 64'(op_cnt_o), 64'(1));
    advance();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      sample();
      advance();
      for (int k = 0; k < NUM_REQ; k++)
        if (!req_valid_i[k] && $urandom_range(99) < 60) issue(k, rnd_op(), rnd_op());
      resp_ready_i = NUM_REQ'($urandom);
    end

    // Reset while a result is held discards it
    resp_ready_i = '0;
    issue(0, rnd_op(), rnd_op());
    sample();
    advance();
    sample();
    advance();
    do_reset();
    sample();
    check("post_rst_idle", 64'(resp_valid_o), 64'(0));
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
